// File: rtl/microPainter_pkg.sv
// Shared types and default geometry for the POV painter column datapath.
package microPainter_pkg;

  localparam int unsigned DEF_NUM_COLS      = 64;
  localparam int unsigned DEF_NUM_LEDS      = 16;
  localparam int unsigned DEF_STEPS_PER_COL = 8;
  localparam int unsigned DEF_PIX_W         = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  // Bit width needed to index n items; never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/col_tracker.sv
// Encoder position tracker: sub-step count and column index, with a pending-column
// flag for the sequencer and a sticky overrun when a column is skipped.
module col_tracker
  import microPainter_pkg::*;
#(
  parameter int unsigned NUM_COLS      = DEF_NUM_COLS,
  parameter int unsigned STEPS_PER_COL = DEF_STEPS_PER_COL
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_enable,
  input  logic                                 i_step,
  input  logic                                 i_dir,
  input  logic                                 i_clr_pending,
  output logic [width_of(NUM_COLS)-1:0]        o_col_idx,
  output logic [width_of(STEPS_PER_COL)-1:0]   o_sub_cnt,
  output logic                                 o_pending,
  output logic                                 o_overrun
);

  localparam int unsigned COL_W = width_of(NUM_COLS);
  localparam int unsigned SUB_W = width_of(STEPS_PER_COL);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(NUM_COLS - 1);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(STEPS_PER_COL - 1);

  logic [COL_W-1:0] r_col, w_col_d;
  logic [SUB_W-1:0] r_sub, w_sub_d;
  logic             r_pending, r_overrun;
  logic             w_col_chg;

  // Next position: wrap sub-count into the column, saturating at both image edges.
  always_comb begin
    w_col_d = r_col;
    w_sub_d = r_sub;
    if (i_enable && i_step) begin
      if (i_dir) begin
        if (r_sub == SUB_MAX) begin
          if (r_col != COL_MAX) begin
            w_sub_d = '0;
            w_col_d = r_col + 1'b1;
          end
        end else begin
          w_sub_d = r_sub + 1'b1;
        end
      end else begin
        if (r_sub == '0) begin
          if (r_col != '0) begin
            w_sub_d = SUB_MAX;
            w_col_d = r_col - 1'b1;
          end
        end else begin
          w_sub_d = r_sub - 1'b1;
        end
      end
    end
    w_col_chg = (w_col_d != r_col);
  end

  // Position, pending and overrun state; a change in the same cycle as the
  // sequencer consumes the pending column re-arms pending without an overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_col     <= '0;
      r_sub     <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_col <= w_col_d;
      r_sub <= w_sub_d;
      if (w_col_chg) begin
        r_pending <= 1'b1;
      end else if (i_clr_pending) begin
        r_pending <= 1'b0;
      end
      if (!i_enable) begin
        r_overrun <= 1'b0;
      end else if (w_col_chg && r_pending && !i_clr_pending) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_col_idx = r_col;
  assign o_sub_cnt = r_sub;
  assign o_pending = r_pending;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/column_sequencer.sv
// Column sequencer: on each new column, reads NUM_LEDS pixels from memory and
// streams them over a valid/ready link, one fetch-wait-send round per pixel.
module column_sequencer
  import microPainter_pkg::*;
#(
  parameter int unsigned NUM_COLS      = DEF_NUM_COLS,
  parameter int unsigned NUM_LEDS      = DEF_NUM_LEDS,
  parameter int unsigned STEPS_PER_COL = DEF_STEPS_PER_COL,
  parameter int unsigned PIX_W         = DEF_PIX_W
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic                                      step,
  input  logic                                      dir,
  output logic                                      mem_rd,
  output logic [width_of(NUM_COLS*NUM_LEDS)-1:0]    mem_addr,
  input  logic [PIX_W-1:0]                          mem_data,
  output logic [PIX_W-1:0]                          pix_data,
  output logic                                      pix_valid,
  input  logic                                      pix_ready,
  output logic                                      pix_last,
  output logic [width_of(NUM_COLS)-1:0]             col_idx,
  output logic                                      busy,
  output logic                                      col_done,
  output logic                                      overrun
);

  localparam int unsigned ADDR_W = width_of(NUM_COLS * NUM_LEDS);
  localparam int unsigned COL_W  = width_of(NUM_COLS);
  localparam int unsigned LED_W  = width_of(NUM_LEDS);
  localparam int unsigned SUB_W  = width_of(STEPS_PER_COL);
  localparam logic [LED_W-1:0] LAST_LED = LED_W'(NUM_LEDS - 1);

  seq_state_e       r_state;
  logic [COL_W-1:0] r_col;
  logic [LED_W-1:0] r_led;
  logic             r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [PIX_W-1:0] r_pix_data;
  logic             r_pix_valid;
  logic             r_pix_last;
  logic             r_busy;
  logic             r_col_done;

  logic [COL_W-1:0] w_col_idx;
  logic [SUB_W-1:0] w_sub_cnt;
  logic             w_pending;
  logic             w_overrun;
  logic             w_launch;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COL_W-1:0] col,
                                                 input logic [LED_W-1:0] led);
    return ADDR_W'(32'(col) * NUM_LEDS + 32'(led));
  endfunction

  col_tracker #(
    .NUM_COLS      (NUM_COLS),
    .STEPS_PER_COL (STEPS_PER_COL)
  ) u_col_tracker (
    .clk           (clk),
    .reset         (reset),
    .i_enable      (enable),
    .i_step        (step),
    .i_dir         (dir),
    .i_clr_pending (w_launch),
    .o_col_idx     (w_col_idx),
    .o_sub_cnt     (w_sub_cnt),
    .o_pending     (w_pending),
    .o_overrun     (w_overrun)
  );

  // Start a column only from idle; the tracker clears pending on the same edge.
  always_comb begin
    w_launch = (r_state == IDLE) && w_pending && enable;
  end

  // Sequencer FSM with registered outputs; mem_rd is raised on entry to FETCH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_led       <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_col_done  <= 1'b0;
    end else begin
      r_mem_rd   <= 1'b0;
      r_col_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_col      <= w_col_idx;
            r_led      <= '0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= pix_addr(w_col_idx, '0);
            r_busy     <= 1'b1;
            r_state    <= FETCH;
          end
        end
        FETCH: r_state <= WAIT;
        WAIT: begin
          r_pix_data  <= mem_data;
          r_pix_valid <= 1'b1;
          r_pix_last  <= (r_led == LAST_LED);
          r_state     <= SEND;
        end
        SEND: begin
          if (pix_ready) begin
            r_pix_valid <= 1'b0;
            if (r_pix_last) begin
              r_col_done <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_led      <= r_led + 1'b1;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= pix_addr(r_col, r_led + 1'b1);
              r_state    <= FETCH;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_mem_addr;
  assign pix_data  = r_pix_data;
  assign pix_valid = r_pix_valid;
  assign pix_last  = r_pix_last;
  assign col_idx   = w_col_idx;
  assign busy      = r_busy;
  assign col_done  = r_col_done;
  assign overrun   = w_overrun;

endmodule

// File: tb/tb_column_sequencer.sv
// Bench for column_sequencer: directed scenarios plus randomized traffic, checked
// by a position/queue reference model and a decoupled output monitor.
module tb_column_sequencer;

  localparam int NC  = 64;
  localparam int NL  = 16;
  localparam int SPC = 8;
  localparam int PW  = 24;
  localparam int AW  = 10;
  localparam int CW  = 6;

  logic          clk = 1'b0;
  logic          reset, enable, step, dir, pix_ready;
  logic          mem_rd, pix_valid, pix_last, busy, col_done, overrun;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_data, pix_data;
  logic [CW-1:0] col_idx;

  always #5 clk = ~clk;

  column_sequencer #(
    .NUM_COLS      (NC),
    .NUM_LEDS      (NL),
    .STEPS_PER_COL (SPC),
    .PIX_W         (PW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .step      (step),
    .dir       (dir),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_last  (pix_last),
    .col_idx   (col_idx),
    .busy      (busy),
    .col_done  (col_done),
    .overrun   (overrun)
  );

  // Image memory content is a hash of the address.
  function automatic logic [PW-1:0] pix_of(input int a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E3779B1 + 32'h01234567;
    return h[31:8];
  endfunction

  // One-cycle read latency memory.
  always @(posedge clk) if (mem_rd) mem_data <= pix_of(int'(mem_addr));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Position is one linear step count p in [0, NC*SPC-1]; column = p / SPC.
  typedef struct {
    logic [PW-1:0] data;
    logic          last;
  } pix_t;

  pix_t exp_pix[$];
  int   exp_addr[$];
  int   m_p = 0;
  bit   m_pending = 0, m_overrun = 0, m_busy = 0, m_valid = 0, m_done = 0;
  int   m_gap = 0, m_pix = 0;
  int   col_old, col_new;
  bit   launch;

  always @(posedge clk) begin
    if (!reset) begin
      m_p = 0; m_pending = 0; m_overrun = 0;
      m_busy = 0; m_valid = 0; m_done = 0; m_gap = 0; m_pix = 0;
      exp_pix.delete();
      exp_addr.delete();
    end else begin
      col_old = m_p / SPC;
      launch  = !m_busy && m_pending && enable;
      // a column: per pixel two cycles of fetch latency, then hold until accepted
      if (m_busy) begin
        if (m_done) begin
          m_done = 0;
          m_busy = 0;
        end else if (m_valid) begin
          if (pix_ready) begin
            m_valid = 0;
            if (m_pix == NL - 1) m_done = 1;
            else begin
              m_pix++;
              m_gap = 2;
            end
          end
        end else if (m_gap > 0) begin
          m_gap--;
          if (m_gap == 0) m_valid = 1;
        end
      end
      if (launch) begin
        m_busy = 1; m_gap = 2; m_pix = 0;
        for (int k = 0; k < NL; k++) begin
          exp_addr.push_back(col_old * NL + k);
          exp_pix.push_back('{pix_of(col_old * NL + k), 1'(k == NL - 1)});
        end
      end
      if (enable && step) begin
        if (dir) begin
          if (m_p < NC * SPC - 1) m_p++;
        end else if (m_p > 0) m_p--;
      end
      col_new = m_p / SPC;
      if (!enable) m_overrun = 0;
      else if (col_new != col_old && m_pending && !launch) m_overrun = 1;
      if (col_new != col_old) m_pending = 1;
      else if (launch) m_pending = 0;
    end
  end

  // ---------------- monitor ----------------
  int n_mem_rd = 0, n_acc = 0, n_done = 0, acc_in_col = 0;
  int fetch_cyc = 0, done_cyc = 0, last_at = 0;
  int sent_cols[$];
  int rd_log[$];
  pix_t e;

  always @(negedge clk) begin
    cyc++;
    chk("busy", busy, m_busy);
    chk("col_idx", col_idx, m_p / SPC);
    chk("sub_cnt", dut.w_sub_cnt, m_p % SPC);
    chk("overrun", overrun, m_overrun);
    chk("col_done", col_done, m_done);
    chk("pix_valid", pix_valid, m_valid);
    chk("mem_rd", mem_rd, m_busy && !m_valid && !m_done && m_gap == 2);
    if (!busy) acc_in_col = 0;
    if (mem_rd) begin
      n_mem_rd++;
      rd_log.push_back(int'(mem_addr));
      if (int'(mem_addr) % NL == 0) begin
        sent_cols.push_back(int'(mem_addr) / NL);
        fetch_cyc = cyc;
      end
      if (exp_addr.size() == 0) chk("mem_rd_unexpected", 1, 0);
      else chk("mem_addr", mem_addr, exp_addr.pop_front());
    end
    if (pix_valid && pix_ready) begin
      if (exp_pix.size() == 0) chk("pixel_unexpected", 1, 0);
      else begin
        e = exp_pix.pop_front();
        chk("pix_data", pix_data, e.data);
        chk("pix_last", pix_last, e.last);
      end
      n_acc++;
      acc_in_col++;
      if (pix_last) last_at = acc_in_col;
    end
    if (col_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk_reset_outputs();
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_last", pix_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_col_done", col_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_col_idx", col_idx, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b0; step = 1'b0; enable = 1'b1; pix_ready = 1'b1;
    repeat (3) tick();
    chk_reset_outputs();
    reset = 1'b1;
    sent_cols.delete();
    rd_log.delete();
  endtask

  task automatic do_steps(input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      tick();
      step = 1'b1;
      dir  = d;
    end
    tick();
    step = 1'b0;
  endtask

  task automatic wait_cols(input int k, input int budget);
    int start = n_done;
    int t = 0;
    while (n_done < start + k && t < budget) begin
      tick();
      t++;
    end
    chk("cols_done_in_budget", n_done - start, k);
  endtask

  task automatic wait_pixel(input int k, input int budget);
    int t = 0;
    bit ok = 0;
    while (t < budget) begin
      if (pix_valid && acc_in_col == k) begin
        ok = 1;
        break;
      end
      tick();
      t++;
    end
    chk("reach_pixel", ok, 1);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((m_busy || m_pending || busy) && t < budget) begin
      tick();
      t++;
    end
    chk("drain_idle", busy, 0);
  endtask

  int rd0, acc0, done0;

  initial begin
    reset = 1'b0; enable = 1'b1; step = 1'b0; dir = 1'b1; pix_ready = 1'b1;
    apply_reset();

    // 8 forward steps -> column 1, full column timing
    rd0 = n_mem_rd; acc0 = n_acc; done0 = n_done;
    do_steps(8, 1'b1);
    chk("t1_col_idx", col_idx, 1);
    wait_cols(1, 200);
    repeat (5) tick();
    chk("t1_mem_rd_count", n_mem_rd - rd0, 16);
    for (int k = 0; k < rd_log.size(); k++) chk("t1_addr_seq", rd_log[k], 16 + k);
    chk("t1_pixels", n_acc - acc0, 16);
    chk("t1_last_on_16th", last_at, 16);
    chk("t1_col_done_once", n_done - done0, 1);
    chk("t1_fetch_to_done", done_cyc - fetch_cyc + 1, 49);

    // stall on pixel 3 of column 2
    do_steps(8, 1'b1);
    wait_pixel(3, 200);
    pix_ready = 1'b0;
    rd0 = n_mem_rd;
    repeat (5) begin
      tick();
      chk("t2_stall_data", pix_data, pix_of(2 * NL + 3));
      chk("t2_stall_last", pix_last, 0);
      chk("t2_stall_valid", pix_valid, 1);
    end
    chk("t2_no_extra_rd", n_mem_rd - rd0, 0);
    pix_ready = 1'b1;
    wait_cols(1, 200);

    // overrun: two column changes while busy on column 1
    apply_reset();
    do_steps(8, 1'b1);
    for (int t = 0; t < 20 && !busy; t++) tick();
    chk("t3_busy", busy, 1);
    do_steps(16, 1'b1);
    chk("t3_overrun", overrun, 1);
    wait_cols(2, 400);
    chk("t3_sent_count", sent_cols.size(), 2);
    if (sent_cols.size() == 2) begin
      chk("t3_first_col", sent_cols[0], 1);
      chk("t3_second_col", sent_cols[1], 3);
    end

    // saturation at both ends
    apply_reset();
    do_steps(1, 1'b0);
    repeat (5) tick();
    chk("t4_col_low", col_idx, 0);
    chk("t4_sub_low", dut.w_sub_cnt, 0);
    chk("t4_no_pending", dut.w_pending, 0);
    chk("t4_idle", busy, 0);
    do_steps(600, 1'b1);
    chk("t4_col_high", col_idx, 63);
    chk("t4_sub_high", dut.w_sub_cnt, 7);
    wait_idle(2000);

    // reset during pixel 7, then enable gating of a pending column
    apply_reset();
    do_steps(8, 1'b1);
    wait_pixel(7, 200);
    reset = 1'b0;
    tick();
    chk_reset_outputs();
    reset = 1'b1;
    rd0 = n_mem_rd; acc0 = n_acc;
    repeat (5) tick();
    chk("t5_no_rd_after_reset", n_mem_rd - rd0, 0);
    chk("t5_no_pix_after_reset", n_acc - acc0, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      step = 1'b1;
      dir  = 1'b1;
    end
    tick();
    step = 1'b0;
    enable = 1'b0;
    rd0 = n_mem_rd;
    repeat (10) tick();
    chk("t5_gated_busy", busy, 0);
    chk("t5_gated_no_rd", n_mem_rd - rd0, 0);
    chk("t5_gated_pending", dut.w_pending, 1);
    sent_cols.delete();
    enable = 1'b1;
    wait_cols(1, 200);
    chk("t5_sent_after_enable", sent_cols.size() > 0 ? sent_cols[0] : -1, 1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset     = ($urandom_range(0, 999) != 0);
      enable    = ($urandom_range(0, 15) != 0);
      step      = ($urandom_range(0, 3) == 0);
      dir       = ($urandom_range(0, 3) != 0);
      pix_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    reset = 1'b1; enable = 1'b1; step = 1'b0; pix_ready = 1'b1;
    wait_idle(3000);
    repeat (3) tick();
    chk("end_addr_queue_empty", exp_addr.size(), 0);
    chk("end_pix_queue_empty", exp_pix.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
